// File: rtl/proc_ctrl_if.sv
// Handshake/control bundle between the core controller and its datapath.
// master = controller side, slave = datapath/opcode source side.
interface proc_ctrl_if #(
  parameter int OPCODE_WIDTH = 8,
  parameter int ALU_OP_WIDTH = 3
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    fproc_ready;
  logic                    sync_enable;
  logic                    cstrobe_in;

  logic [ALU_OP_WIDTH-1:0] alu_opcode;
  logic                    alu_in0_sel;
  logic [1:0]              alu_in1_sel;
  logic                    c_strobe_enable;
  logic                    reg_write_en;
  logic                    instr_ptr_en;
  logic [1:0]              instr_ptr_load_en;
  logic                    qclk_load_en;
  logic                    fproc_out_ready;
  logic                    sync_out_ready;
  logic                    done;
  logic                    err_timeout;
  logic                    err_illegal;

  modport master (
    input  opcode, fproc_ready, sync_enable, cstrobe_in,
    output alu_opcode, alu_in0_sel, alu_in1_sel, c_strobe_enable,
           reg_write_en, instr_ptr_en, instr_ptr_load_en, qclk_load_en,
           fproc_out_ready, sync_out_ready, done, err_timeout, err_illegal
  );

  modport slave (
    output opcode, fproc_ready, sync_enable, cstrobe_in,
    input  alu_opcode, alu_in0_sel, alu_in1_sel, c_strobe_enable,
           reg_write_en, instr_ptr_en, instr_ptr_load_en, qclk_load_en,
           fproc_out_ready, sync_out_ready, done, err_timeout, err_illegal
  );
endinterface

// File: rtl/proc_ctrl_v2.sv
// Multi-cycle instruction sequencer for the distributed processor core.
// OPCODE_WIDTH must be at least ALU_OP_WIDTH+5 so class, in0 select and ALU op do not overlap.
module proc_ctrl_v2 #(
  parameter int          OPCODE_WIDTH  = 8,
  parameter int          ALU_OP_WIDTH  = 3,
  parameter int unsigned FPROC_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  proc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_INIT            = 3'd0,
    S_ALU_PROC        = 3'd1,
    S_JUMP_COND       = 3'd2,
    S_INC_QCLK        = 3'd3,
    S_ALU_FPROC_WAIT  = 3'd4,
    S_JUMP_FPROC_WAIT = 3'd5,
    S_SYNC_WAIT       = 3'd6,
    S_HALT            = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_PULSE      = 4'd0,
    CL_REG_ALU    = 4'd1,
    CL_JUMP_I     = 4'd2,
    CL_JUMP_COND  = 4'd3,
    CL_INC_QCLK   = 4'd4,
    CL_ALU_FPROC  = 4'd5,
    CL_JUMP_FPROC = 4'd6,
    CL_SYNC       = 4'd7,
    CL_DONE       = 4'd8
  } class_e;

  typedef enum logic [1:0] {
    SRC_REG   = 2'd0,
    SRC_QCLK  = 2'd1,
    SRC_FPROC = 2'd2
  } src_e;

  localparam logic [1:0] IP_INCR = 2'd0;
  localparam logic [1:0] IP_LOAD = 2'd1;
  localparam logic [1:0] IP_COND = 2'd2;

  localparam int unsigned CNT_W_RAW = $clog2(FPROC_TIMEOUT + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((FPROC_TIMEOUT == 0) ? 0 : FPROC_TIMEOUT - 1);

  state_e           state_q, state_d;
  src_e             src_q, src_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_illegal_q, err_illegal_d;

  logic [3:0]       op_class;
  logic             timeout_hit;

  logic [1:0]       alu_in1_sel_c;
  logic             c_strobe_enable_c;
  logic             reg_write_en_c;
  logic             instr_ptr_en_c;
  logic [1:0]       instr_ptr_load_en_c;
  logic             qclk_load_en_c;
  logic             fproc_out_ready_c;
  logic             sync_out_ready_c;
  logic             done_c;

  assign op_class    = bus.opcode[OPCODE_WIDTH-1 -: 4];
  assign timeout_hit = (FPROC_TIMEOUT != 0) && (wait_cnt_q == TMO_LAST);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d             = state_q;
    src_d               = src_q;
    wait_cnt_d          = wait_cnt_q;
    err_timeout_d       = err_timeout_q;
    err_illegal_d       = err_illegal_q;
    alu_in1_sel_c       = SRC_REG;
    c_strobe_enable_c   = 1'b0;
    reg_write_en_c      = 1'b0;
    instr_ptr_en_c      = 1'b0;
    instr_ptr_load_en_c = IP_INCR;
    qclk_load_en_c      = 1'b0;
    fproc_out_ready_c   = 1'b0;
    sync_out_ready_c    = 1'b0;
    done_c              = 1'b0;

    unique case (state_q)
      S_INIT: begin
        case (op_class)
          CL_PULSE: begin
            c_strobe_enable_c = 1'b1;
            instr_ptr_en_c    = bus.cstrobe_in;
          end
          CL_REG_ALU: begin
            alu_in1_sel_c = SRC_REG;
            src_d         = SRC_REG;
            state_d       = S_ALU_PROC;
          end
          CL_JUMP_I: begin
            instr_ptr_en_c      = 1'b1;
            instr_ptr_load_en_c = IP_LOAD;
          end
          CL_JUMP_COND: begin
            alu_in1_sel_c = SRC_REG;
            src_d         = SRC_REG;
            state_d       = S_JUMP_COND;
          end
          CL_INC_QCLK: begin
            alu_in1_sel_c = SRC_QCLK;
            src_d         = SRC_QCLK;
            state_d       = S_INC_QCLK;
          end
          CL_ALU_FPROC: begin
            fproc_out_ready_c = 1'b1;
            src_d             = SRC_FPROC;
            wait_cnt_d        = '0;
            state_d           = S_ALU_FPROC_WAIT;
          end
          CL_JUMP_FPROC: begin
            fproc_out_ready_c = 1'b1;
            src_d             = SRC_FPROC;
            wait_cnt_d        = '0;
            state_d           = S_JUMP_FPROC_WAIT;
          end
          CL_SYNC: begin
            sync_out_ready_c = 1'b1;
            state_d          = S_SYNC_WAIT;
          end
          CL_DONE: begin
            state_d = S_HALT;
          end
          default: begin
            err_illegal_d = 1'b1;
            state_d       = S_HALT;
          end
        endcase
      end

      S_ALU_PROC: begin
        alu_in1_sel_c  = src_q;
        reg_write_en_c = 1'b1;
        instr_ptr_en_c = 1'b1;
        state_d        = S_INIT;
      end

      S_INC_QCLK: begin
        alu_in1_sel_c  = src_q;
        qclk_load_en_c = 1'b1;
        instr_ptr_en_c = 1'b1;
        state_d        = S_INIT;
      end

      S_JUMP_COND: begin
        alu_in1_sel_c       = src_q;
        instr_ptr_en_c      = 1'b1;
        instr_ptr_load_en_c = IP_COND;
        state_d             = S_INIT;
      end

      // A result arriving on the last allowed cycle takes priority over the timeout.
      S_ALU_FPROC_WAIT, S_JUMP_FPROC_WAIT: begin
        alu_in1_sel_c = src_q;
        if (bus.fproc_ready) begin
          state_d = (state_q == S_ALU_FPROC_WAIT) ? S_ALU_PROC : S_JUMP_COND;
        end else if (timeout_hit) begin
          err_timeout_d = 1'b1;
          state_d       = S_HALT;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_SYNC_WAIT: begin
        if (bus.sync_enable) begin
          instr_ptr_en_c = 1'b1;
          state_d        = S_INIT;
        end
      end

      S_HALT: begin
        done_c = 1'b1;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // NOTE: reset is synchronous and active-high to match the rest of the core.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q       <= S_INIT;
      src_q         <= SRC_REG;
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  // Every output is forced low while reset is held, even the opcode slices.
  assign bus.alu_opcode        = reset ? '0   : bus.opcode[ALU_OP_WIDTH-1:0];
  assign bus.alu_in0_sel       = reset ? 1'b0 : bus.opcode[ALU_OP_WIDTH];
  assign bus.alu_in1_sel       = reset ? 2'd0 : alu_in1_sel_c;
  assign bus.c_strobe_enable   = reset ? 1'b0 : c_strobe_enable_c;
  assign bus.reg_write_en      = reset ? 1'b0 : reg_write_en_c;
  assign bus.instr_ptr_en      = reset ? 1'b0 : instr_ptr_en_c;
  assign bus.instr_ptr_load_en = reset ? 2'd0 : instr_ptr_load_en_c;
  assign bus.qclk_load_en      = reset ? 1'b0 : qclk_load_en_c;
  assign bus.fproc_out_ready   = reset ? 1'b0 : fproc_out_ready_c;
  assign bus.sync_out_ready    = reset ? 1'b0 : sync_out_ready_c;
  assign bus.done              = reset ? 1'b0 : done_c;
  assign bus.err_timeout       = reset ? 1'b0 : err_timeout_q;
  assign bus.err_illegal       = reset ? 1'b0 : err_illegal_q;

endmodule

// File: doc/proc_ctrl_v2.md
# proc_ctrl_v2

Parametrised multi-cycle control FSM for the distributed processor core. It decodes the instruction class in the current opcode and sequences the instruction pointer, register file, qclk, ALU input muxing, pulse strobe, function-processor (fproc) handshake and inter-core sync handshake. Relative to the first-generation controller it adds:

- generic opcode/ALU-op widths;
- an implemented SYNC barrier state;
- an fproc wait timeout;
- a HALT state with sticky error flags;
- fully specified outputs in every state, with no latched or undefined values.

## Interface
- OPCODE_WIDTH, 8: opcode width; class field is opcode[OPCODE_WIDTH-1 -: 4]; must be ≥ ALU_OP_WIDTH+5.
- ALU_OP_WIDTH, 3: width of alu_opcode = opcode[ALU_OP_WIDTH-1:0]; alu_in0_sel = opcode[ALU_OP_WIDTH].
- FPROC_TIMEOUT, 1023: maximum cycles spent in an fproc wait state; 0 disables the timeout.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- opcode  in  OPCODE_WIDTH  current instruction opcode, stable while the instruction pointer is held.
- fproc_ready  in  1  fproc result valid.
- sync_enable  in  1  sync barrier release.
- cstrobe_in  in  1  pulse strobe fired this cycle.
- alu_opcode  out  ALU_OP_WIDTH  direct slice of opcode.
- alu_in0_sel  out  1  direct slice of opcode.
- alu_in1_sel  out  2  0=REG, 1=QCLK, 2=FPROC.
- c_strobe_enable  out  1  pulse strobe arm.
- reg_write_en  out  1  register file write.
- instr_ptr_en  out  1  instruction pointer update.
- instr_ptr_load_en  out  2  0=increment, 1=load immediate, 2=load if ALU result true.
- qclk_load_en  out  1  load qclk from ALU.
- fproc_out_ready  out  1  fproc request.
- sync_out_ready  out  1  sync request.
- done  out  1  core halted.
- err_timeout  out  1  sticky: fproc timeout occurred.
- err_illegal  out  1  sticky: illegal class decoded.

## Operation
- Instruction classes: 0 PULSE, 1 REG_ALU, 2 JUMP_I, 3 JUMP_COND, 4 INC_QCLK, 5 ALU_FPROC, 6 JUMP_FPROC, 7 SYNC, 8 DONE; 9–15 are illegal.
- States: INIT, ALU_PROC, JUMP_COND, INC_QCLK, ALU_FPROC_WAIT, JUMP_FPROC_WAIT, SYNC_WAIT, HALT. The state register is 3 bits.
- Output defaults: every output not named below is 0, including in HALT. All outputs are combinational from state, opcode and inputs.
- INIT, by class:
  - PULSE: c_strobe_enable=1; instr_ptr_en=cstrobe_in; stay in INIT.
  - REG_ALU: alu_in1_sel=REG; go to ALU_PROC.
  - JUMP_I: instr_ptr_en=1, instr_ptr_load_en=1; stay in INIT.
  - JUMP_COND: alu_in1_sel=REG; go to JUMP_COND.
  - INC_QCLK: alu_in1_sel=QCLK; go to INC_QCLK.
  - ALU_FPROC: fproc_out_ready=1; go to ALU_FPROC_WAIT.
  - JUMP_FPROC: fproc_out_ready=1; go to JUMP_FPROC_WAIT.
  - SYNC: sync_out_ready=1; go to SYNC_WAIT.
  - DONE: go to HALT.
  - Illegal: set err_illegal; go to HALT.
- src register: a registered 2-bit copy of the alu_in1 source.
  - Loaded on dispatch from INIT: REG for REG_ALU/JUMP_COND, QCLK for INC_QCLK, FPROC for the fproc classes.
  - alu_in1_sel = src in ALU_PROC, JUMP_COND, INC_QCLK and both fproc wait states.
- ALU_PROC: reg_write_en=1, instr_ptr_en=1; go to INIT.
- INC_QCLK: qclk_load_en=1, instr_ptr_en=1; go to INIT.
- JUMP_COND: instr_ptr_en=1, instr_ptr_load_en=2; go to INIT.
- ALU_FPROC_WAIT / JUMP_FPROC_WAIT:
  - fproc_ready=1 → ALU_PROC / JUMP_COND respectively.
  - Otherwise wait_cnt increments.
  - If FPROC_TIMEOUT≠0 and wait_cnt==FPROC_TIMEOUT-1 with fproc_ready=0: set err_timeout and go to HALT.
  - fproc_ready on the last allowed cycle wins over the timeout.
- SYNC_WAIT: sync_enable=1 → instr_ptr_en=1, go to INIT; otherwise stay. No timeout.
- HALT: done=1; the state is left only by reset.
- wait_cnt: width $clog2(FPROC_TIMEOUT+1) (minimum 1); cleared on entry to either fproc wait state; saturates, never wraps.

## Timing
- Reset, sampled on a clk edge: state=INIT, src=REG, wait_cnt=0, err flags=0.
- While reset is high, all outputs are 0, including c_strobe_enable in INIT/PULSE.
- Reset takes effect mid-operation from any state, with no completion of the pending instruction.
- Latencies, counted from the INIT cycle to the instr_ptr_en cycle:
  - JUMP_I: 0 cycles.
  - PULSE: 0 cycles after cstrobe_in.
  - REG_ALU, JUMP_COND, INC_QCLK: 1 cycle.
  - ALU_FPROC / JUMP_FPROC: 2 cycles + fproc wait cycles.
  - SYNC: 1 cycle + sync wait cycles.
- fproc_out_ready and sync_out_ready are single-cycle pulses, asserted only in the INIT dispatch cycle.
- fproc_ready or sync_enable arriving in the same cycle as the request pulse is ignored; it is only sampled in the wait state.
- Error flags are set on the clk edge that enters HALT. done is asserted from the first HALT cycle.

## Test plan
- Reset, then REG_ALU opcode 0x13: cycle 0 alu_in1_sel=0, alu_opcode=3; cycle 1 reg_write_en=1 and instr_ptr_en=1; cycle 2 back in INIT.
- ALU_FPROC 0x50 with fproc_ready high 3 cycles after the request: fproc_out_ready=1 for exactly one cycle; alu_in1_sel=2 through the wait and the ALU_PROC cycle; reg_write_en=1 on the cycle after fproc_ready.
- FPROC_TIMEOUT=4, JUMP_FPROC 0x60, fproc_ready held 0: HALT entered after 4 wait cycles; err_timeout=1, done=1. Repeat with fproc_ready on the 4th wait cycle: JUMP_COND with instr_ptr_load_en=2, no error.
- SYNC 0x70, sync_enable low for 5 cycles then high: sync_out_ready one-cycle pulse; instr_ptr_en=1 only in the release cycle.
- PULSE 0x00 with cstrobe_in toggling: c_strobe_enable=1 continuously; instr_ptr_en mirrors cstrobe_in. Assert reset mid-stream: all outputs go to 0.
- Opcode 0xA0: err_illegal=1, done=1 persisting across opcode changes; reset clears both.
